// File: rtl/uart_pkg.sv
// uart_pkg: shared receiver state encoding, frame width and parity helper.
package uart_pkg;
   localparam int UART_DATA_BITS = 8;
   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_BREAK} rx_state_t;
   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction
endpackage

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: serial line in, received byte and status strobes out.
interface uart_receiver_if;
   logic       rx;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_err;
   logic       parity_err;
   logic       rx_busy;
   modport master (input rx, output data_out, data_valid, frame_err, parity_err, rx_busy);
   modport slave (output rx, input data_out, data_valid, frame_err, parity_err, rx_busy);
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop synchronizer for the serial line, resets to idle-high.
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   output logic rx_s
);
   logic s1;
   always_ff @(posedge clk or posedge rst)
      if (rst) {rx_s, s1} <= 2'b11;
      else     {rx_s, s1} <= {s1, rx};
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 UART receiver with mid-bit sampling and framing-error detection.
// Define RX_PARITY_EN to expect one even-parity bit between data and stop.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int CLOCKS_PER_PULSE = 16
) (
   input logic             clk,
   input logic             rst,
   uart_receiver_if.master bus
);
   localparam int CW = $clog2(CLOCKS_PER_PULSE);
   localparam logic [CW-1:0] HALF = CW'(CLOCKS_PER_PULSE / 2 - 1);
   localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_PULSE - 1);
   localparam rx_state_t AFTER_DATA =
`ifdef RX_PARITY_EN
      RX_PARITY;
`else
      RX_STOP;
`endif
   logic rx_s;
   rx_state_t state, state_n;
   logic [CW-1:0] c_clocks, c_clocks_n;
   logic [2:0] c_bits, c_bits_n;
   logic [UART_DATA_BITS-1:0] shift, shift_n, dout, dout_n;
   logic valid, valid_n, ferr, ferr_n, perr, perr_n, pflag, pflag_n;
   uart_rx_sync u_sync (.clk(clk), .rst(rst), .rx(bus.rx), .rx_s(rx_s));
   always_comb begin
      state_n    = state;
      c_clocks_n = c_clocks + 1'b1;
      c_bits_n   = c_bits;
      shift_n    = shift;
      dout_n     = dout;
      pflag_n    = pflag;
      valid_n    = 1'b0;
      ferr_n     = 1'b0;
      perr_n     = 1'b0;
      case (state)
         RX_IDLE: begin
            c_clocks_n = '0;
            state_n    = rx_s ? RX_IDLE : RX_START;
         end
         RX_START: if (c_clocks == HALF) begin
            c_clocks_n = '0;
            c_bits_n   = '0;
            pflag_n    = 1'b0;
            state_n    = rx_s ? RX_IDLE : RX_DATA;
         end
         RX_DATA: if (c_clocks == LAST) begin
            c_clocks_n = '0;
            c_bits_n   = c_bits + 3'd1;
            shift_n    = {rx_s, shift[UART_DATA_BITS-1:1]};
            state_n    = (c_bits == 3'd7) ? AFTER_DATA : RX_DATA;
         end
         RX_PARITY: if (c_clocks == LAST) begin
            c_clocks_n = '0;
            pflag_n    = rx_s ^ even_parity(shift);
            state_n    = RX_STOP;
         end
         RX_STOP: if (c_clocks == LAST) begin
            c_clocks_n = '0;
            valid_n    = rx_s & ~pflag;
            perr_n     = rx_s & pflag;
            ferr_n     = ~rx_s;
            dout_n     = valid_n ? shift : dout;
            state_n    = rx_s ? RX_IDLE : RX_BREAK;
         end
         RX_BREAK: begin
            c_clocks_n = '0;
            state_n    = rx_s ? RX_IDLE : RX_BREAK;
         end
         default: state_n = RX_IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state    <= RX_IDLE;
         c_clocks <= '0;
         c_bits   <= '0;
         shift    <= '0;
         dout     <= '0;
         pflag    <= 1'b0;
         valid    <= 1'b0;
         ferr     <= 1'b0;
         perr     <= 1'b0;
      end else begin
         state    <= state_n;
         c_clocks <= c_clocks_n;
         c_bits   <= c_bits_n;
         shift    <= shift_n;
         dout     <= dout_n;
         pflag    <= pflag_n;
         valid    <= valid_n;
         ferr     <= ferr_n;
         perr     <= perr_n;
      end
   assign bus.data_out   = dout;
   assign bus.data_valid = valid;
   assign bus.frame_err  = ferr;
`ifdef RX_PARITY_EN
   assign bus.parity_err = perr;
`else
   assign bus.parity_err = perr & 1'b0;
`endif
   assign bus.rx_busy    = (state != RX_IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames with a scoreboard of expected strobes checked by a monitor.
module tb_uart_receiver;
`ifdef RX_PARITY_EN
   localparam bit PAR = 1'b1;
`else
   localparam bit PAR = 1'b0;
`endif
   localparam int CPP = 16;
   localparam int LAT = PAR ? 171 : 155;
   typedef struct {logic [2:0] kind; logic [7:0] data; int lat;} exp_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int n_chk = 0, n_pass = 0, cyc = 0, t_edge = 0;
   exp_t sb[$];
   logic [2:0] prev_strobe = 3'b000;
   uart_receiver_if bus ();
   uart_receiver #(.CLOCKS_PER_PULSE(CPP)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask
   task automatic drive(input logic v, input int n);
      bus.rx = v;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   task automatic send_frame(input logic [7:0] d, input logic stop, input logic par);
      t_edge = cyc;
      drive(1'b0, CPP);
      for (int i = 0; i < 8; i++) drive(d[i], CPP);
      if (PAR) drive(par, CPP);
      drive(stop, CPP);
   endtask
   task automatic push(input logic [2:0] k, input logic [7:0] d, input int lat);
      exp_t e;
      e.kind = k;
      e.data = d;
      e.lat  = lat;
      sb.push_back(e);
   endtask
   always @(negedge clk) begin
      logic [2:0] s;
      exp_t e;
      s = {bus.data_valid, bus.frame_err, bus.parity_err};
      if (!rst && s != 3'b000) begin
         chk("strobe_onehot", $countones(s), 1);
         chk("strobe_no_repeat", prev_strobe, 3'b000);
         if (sb.size() == 0) chk("unexpected_strobe", s, 3'b000);
         else begin
            e = sb.pop_front();
            chk("strobe_kind", s, e.kind);
            chk("data_out", bus.data_out, e.data);
            if (e.lat > 0) chk("latency", cyc - t_edge, e.lat);
         end
      end
      prev_strobe <= s;
   end
   initial begin
      int bc;
      logic [7:0] d5;
      bus.rx = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data_out", bus.data_out, 8'h00);
      chk("rst_data_valid", bus.data_valid, 1'b0);
      chk("rst_frame_err", bus.frame_err, 1'b0);
      chk("rst_parity_err", bus.parity_err, 1'b0);
      chk("rst_rx_busy", bus.rx_busy, 1'b0);
      rst = 1'b0;
      drive(1'b1, 5);
      push(3'b100, 8'hA5, LAT);
      send_frame(8'hA5, 1'b1, 1'b0);
      drive(1'b1, 20);
      bc = 0;
      fork
         begin
            drive(1'b0, 4);
            drive(1'b1, 30);
         end
         repeat (40) @(negedge clk) bc += bus.rx_busy;
      join
      chk("glitch_busy_cycles", bc, 8);
      push(3'b010, 8'hA5, 0);
      send_frame(8'h3C, 1'b0, 1'b0);
      drive(1'b0, 40);
      chk("break_busy", bus.rx_busy, 1'b1);
      drive(1'b1, 6);
      chk("break_released", bus.rx_busy, 1'b0);
      drive(1'b1, 10);
      push(3'b100, 8'h00, 0);
      push(3'b100, 8'hFF, 0);
      push(3'b100, 8'h81, 0);
      send_frame(8'h00, 1'b1, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0);
      send_frame(8'h81, 1'b1, 1'b0);
      drive(1'b1, 20);
      d5 = 8'h5A;
      drive(1'b0, CPP);
      for (int i = 0; i < 4; i++) drive(d5[i], CPP);
      drive(d5[4], CPP / 2);
      rst = 1'b1;
      bus.rx = 1'b1;
      @(negedge clk);
      chk("midrst_data_out", bus.data_out, 8'h00);
      chk("midrst_valid", bus.data_valid, 1'b0);
      chk("midrst_busy", bus.rx_busy, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(1'b1, 20);
      push(3'b100, 8'h12, 0);
      send_frame(8'h12, 1'b1, 1'b0);
      drive(1'b1, 20);
`ifdef RX_PARITY_EN
      push(3'b001, 8'h12, 0);
      send_frame(8'h07, 1'b1, 1'b0);
      drive(1'b1, 20);
      push(3'b100, 8'h07, 0);
      send_frame(8'h07, 1'b1, 1'b1);
      drive(1'b1, 20);
`endif
      for (int i = 0; i < 2000 && sb.size() != 0; i++) @(posedge clk);
      chk("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
